// File: rtl/mult_seq_ctrl.sv
// Sequencer for the registered Wallace-tree multiplier.
// Stalls the pipeline, runs one signed multiply, writes lo/hi back.
module mult_seq_ctrl #(
  parameter int N    = 32,
  parameter int LAT  = 2,
  parameter int RA_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [N-1:0]    op_a,
  input  logic [N-1:0]    op_b,
  input  logic [RA_W-1:0] rd_lo,
  input  logic [RA_W-1:0] rd_hi,
  input  logic            flush,
  output logic            mult_en,
  output logic [N-1:0]    mult_a,
  output logic [N-1:0]    mult_b,
  input  logic [2*N-1:0]  mult_result,
  output logic            stall,
  output logic            wb_valid,
  output logic [RA_W-1:0] wb_addr,
  output logic [N-1:0]    wb_data,
  input  logic            wb_ack,
  output logic            busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {
    IDLE, COMPUTE, CAPTURE, WB_LO, WB_HI
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [RA_W-1:0] lo_q;
  logic [RA_W-1:0] hi_q;
  logic [N-1:0]    prod_hi_q;

  logic accept;
  logic abort;
  logic done;

  assign accept = req_valid & req_ready & ~flush;
  assign abort  = flush & ((state == COMPUTE) | (state == CAPTURE));
  assign done   = (state == WB_HI) & (~wb_valid | wb_ack);

  // Accept cycle must also freeze upstream, so stall is not registered.
  assign stall = busy | accept;

  // State walk with outputs registered for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      prod_hi_q <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      mult_en   <= 1'b0;
      mult_a    <= '0;
      mult_b    <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else if (abort || done) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      mult_en   <= 1'b0;
      mult_a    <= '0;
      mult_b    <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= COMPUTE;
            cnt       <= '0;
            lo_q      <= rd_lo;
            hi_q      <= rd_hi;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            mult_en   <= 1'b1;
            mult_a    <= op_a;
            mult_b    <= op_b;
          end
        end
        COMPUTE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(LAT - 1)) begin
            state   <= CAPTURE;
            mult_en <= 1'b0;
            mult_a  <= '0;
            mult_b  <= '0;
          end
        end
        CAPTURE: begin
          state     <= WB_LO;
          prod_hi_q <= mult_result[2*N-1:N];
          wb_valid  <= (lo_q != '0);
          wb_addr   <= lo_q;
          wb_data   <= (lo_q != '0) ? mult_result[N-1:0] : '0;
        end
        WB_LO: begin
          if (!wb_valid || wb_ack) begin
            state    <= WB_HI;
            wb_valid <= (hi_q != '0);
            wb_addr  <= hi_q;
            wb_data  <= (hi_q != '0) ? prod_hi_q : '0;
          end
        end
        WB_HI: begin
          state <= WB_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: transaction-timeline model plus
// directed literal checks and a randomized run.
module tb_mult_seq_ctrl;

  localparam int N    = 32;
  localparam int LAT  = 2;
  localparam int RA_W = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic [RA_W-1:0] rd_lo;
  logic [RA_W-1:0] rd_hi;
  logic            flush;
  logic            mult_en;
  logic [N-1:0]    mult_a;
  logic [N-1:0]    mult_b;
  logic [2*N-1:0]  mult_result;
  logic            stall;
  logic            wb_valid;
  logic [RA_W-1:0] wb_addr;
  logic [N-1:0]    wb_data;
  logic            wb_ack;
  logic            busy;

  mult_seq_ctrl #(.N(N), .LAT(LAT), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_a(op_a), .op_b(op_b),
    .rd_lo(rd_lo), .rd_hi(rd_hi),
    .flush(flush),
    .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b),
    .mult_result(mult_result),
    .stall(stall),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ack(wb_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Two-register signed multiplier, both stages gated by mult_en.
  logic signed [N-1:0]   ia = '0;
  logic signed [N-1:0]   ib = '0;
  logic signed [2*N-1:0] mres = '0;
  assign mult_result = mres;
  always @(posedge clk) begin
    if (mult_en) begin
      ia   <= mult_a;
      ib   <= mult_b;
      mres <= ia * ib;
    end
  end

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int acc  = 0;
  int en_cnt = 0;

  typedef struct {
    int              cyc;
    logic [RA_W-1:0] addr;
    logic [N-1:0]    data;
  } wr_t;
  wr_t log_q[$];

  // Transaction model: phase counts cycles since accept.
  bit              m_act = 0;
  int              m_ph  = 0;
  int              m_sub = 0;
  logic [N-1:0]    m_a, m_b;
  logic [RA_W-1:0] m_lo, m_hi;
  logic [2*N-1:0]  m_p;

  logic [N-1:0]    cur_a  = '0;
  logic [N-1:0]    cur_b  = '0;
  logic [RA_W-1:0] cur_lo = '0;
  logic [RA_W-1:0] cur_hi = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare();
    logic            e_en;
    logic            ev;
    logic [RA_W-1:0] ea;
    logic [N-1:0]    ed;
    e_en = m_act && m_ph >= 1 && m_ph <= LAT;
    ev = 1'b0;
    ea = '0;
    ed = '0;
    if (m_act && m_sub == 1) begin
      ev = (m_lo != 0); ea = m_lo; ed = m_p[N-1:0];
    end else if (m_act && m_sub == 2) begin
      ev = (m_hi != 0); ea = m_hi; ed = m_p[2*N-1:N];
    end
    chk("req_ready", 64'(req_ready), 64'(!m_act));
    chk("busy", 64'(busy), 64'(m_act));
    chk("stall", 64'(stall), 64'(m_act || (req_valid && !flush)));
    chk("mult_en", 64'(mult_en), 64'(e_en));
    chk("mult_a", 64'(mult_a), e_en ? 64'(m_a) : 64'd0);
    chk("mult_b", 64'(mult_b), e_en ? 64'(m_b) : 64'd0);
    chk("wb_valid", 64'(wb_valid), 64'(ev));
    if (ev) begin
      chk("wb_addr", 64'(wb_addr), 64'(ea));
      chk("wb_data", 64'(wb_data), 64'(ed));
    end
  endtask

  task automatic model_update(input logic rv, input logic fl,
                              input logic ack);
    logic signed [2*N-1:0] sa, sb;
    if (!m_act) begin
      if (rv && !fl) begin
        m_act = 1; m_ph = 1; m_sub = 0;
        m_a = cur_a; m_b = cur_b; m_lo = cur_lo; m_hi = cur_hi;
        sa = $signed(cur_a);
        sb = $signed(cur_b);
        m_p = sa * sb;
      end
    end else if (m_sub == 0) begin
      if (fl) m_act = 0;
      else begin
        m_ph++;
        if (m_ph == LAT + 2) m_sub = 1;
      end
    end else if (m_sub == 1) begin
      if (m_lo == 0 || ack) m_sub = 2;
    end else begin
      if (m_hi == 0 || ack) m_act = 0;
    end
  endtask

  task automatic drive(input logic rv, input logic fl, input logic ack);
    req_valid = rv;
    flush     = fl;
    wb_ack    = ack;
    op_a      = cur_a;
    op_b      = cur_b;
    rd_lo     = cur_lo;
    rd_hi     = cur_hi;
  endtask

  task automatic step(input logic rv, input logic fl, input logic ack);
    @(negedge clk);
    drive(rv, fl, ack);
    #1;
    compare();
    if (mult_en) en_cnt++;
    if (!m_act && rv && !fl) acc = cyc;
    if (wb_valid && wb_ack) log_q.push_back('{cyc, wb_addr, wb_data});
    @(posedge clk);
    model_update(rv, fl, ack);
    cyc++;
  endtask

  task automatic set_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [RA_W-1:0] lo,
                        input logic [RA_W-1:0] hi);
    cur_a = a; cur_b = b; cur_lo = lo; cur_hi = hi;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_wr(input string nm, input int idx, input int dcyc,
                        input logic [RA_W-1:0] a, input logic [N-1:0] d);
    if (log_q.size() <= idx) begin
      chk({nm, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
    end else begin
      chk({nm, "_cyc"}, 64'(log_q[idx].cyc - acc), 64'(dcyc));
      chk({nm, "_addr"}, 64'(log_q[idx].addr), 64'(a));
      chk({nm, "_data"}, 64'(log_q[idx].data), 64'(d));
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mult_en", 64'(mult_en), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // 3*4 with ack tied high
    set_op(32'd3, 32'd4, 3'd1, 3'd2);
    log_q.delete();
    en_cnt = 0;
    step(1'b1, 1'b0, 1'b1);
    idle(8);
    chk("t1_en_cycles", 64'(en_cnt), 64'd2);
    chk("t1_nwr", 64'(log_q.size()), 64'd2);
    chk_wr("t1_lo", 0, 4, 3'd1, 32'h0000000C);
    chk_wr("t1_hi", 1, 5, 3'd2, 32'h00000000);

    // -1 * 1
    set_op(32'hFFFFFFFF, 32'd1, 3'd3, 3'd4);
    log_q.delete();
    step(1'b1, 1'b0, 1'b1);
    idle(8);
    chk_wr("t2a_lo", 0, 4, 3'd3, 32'hFFFFFFFF);
    chk_wr("t2a_hi", 1, 5, 3'd4, 32'hFFFFFFFF);

    // most-negative squared
    set_op(32'h80000000, 32'h80000000, 3'd6, 3'd7);
    log_q.delete();
    step(1'b1, 1'b0, 1'b1);
    idle(8);
    chk_wr("t2b_lo", 0, 4, 3'd6, 32'h00000000);
    chk_wr("t2b_hi", 1, 5, 3'd7, 32'h40000000);

    // ack withheld for 3 cycles in WB_LO
    set_op(32'd100, 32'hFFFFFFFE, 3'd2, 3'd3);
    log_q.delete();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    idle(6);
    chk_wr("t3_lo", 0, 7, 3'd2, 32'hFFFFFF38);
    chk_wr("t3_hi", 1, 8, 3'd3, 32'hFFFFFFFF);

    // flush in the second COMPUTE cycle, then a fresh request
    set_op(32'd9, 32'd9, 3'd1, 3'd1);
    log_q.delete();
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    #1;
    chk("t4_ready", 64'(req_ready), 64'd1);
    chk("t4_wb_valid", 64'(wb_valid), 64'd0);
    set_op(32'd5, 32'd5, 3'd4, 3'd5);
    step(1'b1, 1'b0, 1'b1);
    idle(8);
    chk("t4_nwr", 64'(log_q.size()), 64'd2);
    chk_wr("t4_lo", 0, 4, 3'd4, 32'd25);
    chk_wr("t4_hi", 1, 5, 3'd5, 32'd0);

    // rd_lo skipped, req_valid held through the busy window
    set_op(32'd7, 32'd6, 3'd0, 3'd5);
    log_q.delete();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    idle(8);
    chk("t5_nwr", 64'(log_q.size()), 64'd1);
    chk_wr("t5_hi", 0, 5, 3'd5, 32'd0);

    // async reset in the middle of WB_HI
    set_op(32'd11, 32'd13, 3'd1, 3'd2);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1);
    #1;
    chk("t6_pre_wb_valid", 64'(wb_valid), 64'd1);
    chk("t6_pre_wb_addr", 64'(wb_addr), 64'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_wb_valid", 64'(wb_valid), 64'd0);
    chk("t6_req_ready", 64'(req_ready), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_stall", 64'(stall), 64'd0);
    m_act = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
      set_op(a, b, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
           1'($urandom_range(0, 1)));
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
